local_memory_arbiter: RTL and testbench

Round-robin arbiter that shares the secondary interface of the local SRAM memory interface between several bus requesters, such as the Wishbone slave, the debug port and the DMA engine. It latches one granted requester and routes that requester's signals to the memory port until the transfer completes. It returns a done pulse and read data to the granted requester, and aborts transfers that stall too long. It sits between the requester ports and the memory interface's secondary port.

---
 rtl/local_memory_arbiter_pkg.sv | 23 ++
 rtl/local_memory_arbiter_if.sv | 62 ++++++
 rtl/local_memory_arbiter_round_robin_picker.sv | 31 +++
 rtl/local_memory_arbiter.sv | 109 ++++++++++
 tb/tb_local_memory_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/local_memory_arbiter_pkg.sv
// rtl/local_memory_arbiter_pkg.sv - shared types and sizing helpers for the local memory arbiter
package local_memory_arbiter_pkg;

    localparam int MIN_REQUESTERS = 2;
    localparam int MAX_REQUESTERS = 8;
    localparam int MAX_TIMEOUT_CYCLES = 65535;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RECOVER = 2'd2
    } arbState_t;

    // Index width for a requester vector; a single-bit index is kept even for tiny counts.
    function automatic int grantWidth(input int requesterCount);
        return (requesterCount > 1) ? $clog2(requesterCount) : 1;
    endfunction

    function automatic int counterWidth(input int timeoutCycles);
        return (timeoutCycles > 0) ? $clog2(timeoutCycles + 1) : 1;
    endfunction

endpackage

// File: rtl/local_memory_arbiter_if.sv
// rtl/local_memory_arbiter_if.sv - requester and secondary-port signal bundle for the arbiter
interface local_memory_arbiter_if #(
    parameter int ADDRESS_SIZE    = 24,
    parameter int REQUESTER_COUNT = 3
);

    logic [REQUESTER_COUNT-1:0]              reqEnable;
    logic [REQUESTER_COUNT-1:0]              reqWriteEnable;
    logic [REQUESTER_COUNT*ADDRESS_SIZE-1:0] reqAddress;
    logic [REQUESTER_COUNT*4-1:0]            reqByteSelect;
    logic [REQUESTER_COUNT*32-1:0]           reqDataWrite;
    logic [31:0]                             reqDataRead;
    logic [REQUESTER_COUNT-1:0]              reqDone;
    logic [REQUESTER_COUNT-1:0]              reqError;

    logic                                    memEnable;
    logic                                    memWriteEnable;
    logic [ADDRESS_SIZE-1:0]                 memAddress;
    logic [3:0]                              memByteSelect;
    logic [31:0]                             memDataWrite;
    logic [31:0]                             memDataRead;
    logic                                    memBusy;

    // Arbiter side: accepts requests and drives the secondary port.
    modport slave (
        input  reqEnable,
        input  reqWriteEnable,
        input  reqAddress,
        input  reqByteSelect,
        input  reqDataWrite,
        output reqDataRead,
        output reqDone,
        output reqError,
        output memEnable,
        output memWriteEnable,
        output memAddress,
        output memByteSelect,
        output memDataWrite,
        input  memDataRead,
        input  memBusy
    );

    // Environment side: requesters plus the memory secondary port.
    modport master (
        output reqEnable,
        output reqWriteEnable,
        output reqAddress,
        output reqByteSelect,
        output reqDataWrite,
        input  reqDataRead,
        input  reqDone,
        input  reqError,
        input  memEnable,
        input  memWriteEnable,
        input  memAddress,
        input  memByteSelect,
        input  memDataWrite,
        output memDataRead,
        output memBusy
    );

endinterface

// File: rtl/local_memory_arbiter_round_robin_picker.sv
// rtl/local_memory_arbiter_round_robin_picker.sv - combinational round-robin pick starting after lastGrant
module round_robin_picker #(
    parameter int REQUESTER_COUNT = 3,
    parameter int GRANT_WIDTH     = 2
) (
    input  logic [REQUESTER_COUNT-1:0] request,
    input  logic [GRANT_WIDTH-1:0]     lastGrant,
    output logic [GRANT_WIDTH-1:0]     grant,
    output logic                       valid
);

    int distance;
    int bestDistance;

    // Distance 0 is the requester right after lastGrant; the smallest distance among set bits wins.
    always_comb begin
        grant        = '0;
        valid        = 1'b0;
        distance     = 0;
        bestDistance = REQUESTER_COUNT;
        for (int idx = 0; idx < REQUESTER_COUNT; idx++) begin
            distance = (idx - int'(lastGrant) - 1 + 2 * REQUESTER_COUNT) % REQUESTER_COUNT;
            if (request[idx] && (distance < bestDistance)) begin
                bestDistance = distance;
                grant        = GRANT_WIDTH'(idx);
                valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/local_memory_arbiter.sv
// rtl/local_memory_arbiter.sv - round-robin arbiter sharing the SRAM secondary port between requesters
module local_memory_arbiter
    import local_memory_arbiter_pkg::*;
#(
    parameter int ADDRESS_SIZE    = 24,
    parameter int REQUESTER_COUNT = 3,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    local_memory_arbiter_if.slave  bus
);

    localparam int GRANT_WIDTH = grantWidth(REQUESTER_COUNT);
    localparam int COUNT_WIDTH = counterWidth(TIMEOUT_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST  = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX   = COUNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [GRANT_WIDTH-1:0] GRANT_RESET = GRANT_WIDTH'(REQUESTER_COUNT - 1);

    arbState_t                   state;
    logic [GRANT_WIDTH-1:0]      grant;
    logic [GRANT_WIDTH-1:0]      lastGrant;
    logic [COUNT_WIDTH-1:0]      busyCount;

    logic [GRANT_WIDTH-1:0]      pickGrant;
    logic                        pickValid;

    logic                        inGrant;
    logic                        grantedEnable;
    logic                        withdrawn;
    logic                        transferDone;
    logic                        timeoutHit;
    logic [REQUESTER_COUNT-1:0]  grantOneHot;

    round_robin_picker #(
        .REQUESTER_COUNT (REQUESTER_COUNT),
        .GRANT_WIDTH     (GRANT_WIDTH)
    ) picker (
        .request   (bus.reqEnable),
        .lastGrant (lastGrant),
        .grant     (pickGrant),
        .valid     (pickValid)
    );

    // Withdrawal takes precedence: a dropped request never completes even if memBusy is low.
    always_comb begin
        inGrant       = (state == GRANT);
        grantedEnable = bus.reqEnable[grant];
        withdrawn     = inGrant && !grantedEnable;
        transferDone  = inGrant && grantedEnable && !bus.memBusy;
        timeoutHit    = inGrant && grantedEnable && bus.memBusy && (busyCount == COUNT_LAST);
        grantOneHot   = REQUESTER_COUNT'(1) << grant;
    end

    always_comb begin
        bus.memEnable      = 1'b0;
        bus.memWriteEnable = 1'b0;
        bus.memAddress     = '0;
        bus.memByteSelect  = '0;
        bus.memDataWrite   = '0;
        if (inGrant) begin
            bus.memEnable      = grantedEnable;
            bus.memWriteEnable = bus.reqWriteEnable[grant];
            bus.memAddress     = bus.reqAddress[grant * ADDRESS_SIZE +: ADDRESS_SIZE];
            bus.memByteSelect  = bus.reqByteSelect[grant * 4 +: 4];
            bus.memDataWrite   = bus.reqDataWrite[grant * 32 +: 32];
        end
    end

    always_comb begin
        bus.reqDone     = transferDone ? grantOneHot : '0;
        bus.reqError    = (withdrawn || timeoutHit) ? grantOneHot : '0;
        bus.reqDataRead = transferDone ? bus.memDataRead : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            lastGrant <= GRANT_RESET;
            busyCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pickValid) begin
                        grant     <= pickGrant;
                        lastGrant <= pickGrant;
                        busyCount <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (withdrawn || transferDone || timeoutHit) begin
                        state <= RECOVER;
                    end else if (bus.memBusy && (busyCount != COUNT_MAX)) begin
                        busyCount <= busyCount + COUNT_WIDTH'(1);
                    end
                end
                RECOVER: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_local_memory_arbiter.sv
// tb/tb_local_memory_arbiter.sv - randomized and directed bench for local_memory_arbiter
module tb_local_memory_arbiter;

    localparam int N     = 3;
    localparam int AW    = 24;
    localparam int TO_A  = 255;
    localparam int TO_B  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    en   [2];
    logic [N-1:0]    we   [2];
    logic [N*AW-1:0] addr [2];
    logic [N*4-1:0]  bsel [2];
    logic [N*32-1:0] wdat [2];
    logic [31:0]     rdat [2];
    logic            busy [2];

    logic [N-1:0]    oDone [2];
    logic [N-1:0]    oErr  [2];
    logic [31:0]     oRead [2];
    logic            oEn   [2];
    logic            oWe   [2];
    logic [AW-1:0]   oAddr [2];
    logic [3:0]      oBs   [2];
    logic [31:0]     oWd   [2];

    local_memory_arbiter_if #(.ADDRESS_SIZE(AW), .REQUESTER_COUNT(N)) busA ();
    local_memory_arbiter_if #(.ADDRESS_SIZE(AW), .REQUESTER_COUNT(N)) busB ();

    local_memory_arbiter #(.ADDRESS_SIZE(AW), .REQUESTER_COUNT(N), .TIMEOUT_CYCLES(TO_A)) dutA (
        .clk (clk), .rst (rst), .bus (busA.slave));
    local_memory_arbiter #(.ADDRESS_SIZE(AW), .REQUESTER_COUNT(N), .TIMEOUT_CYCLES(TO_B)) dutB (
        .clk (clk), .rst (rst), .bus (busB.slave));

    assign busA.reqEnable = en[0];   assign busB.reqEnable = en[1];
    assign busA.reqWriteEnable = we[0]; assign busB.reqWriteEnable = we[1];
    assign busA.reqAddress = addr[0]; assign busB.reqAddress = addr[1];
    assign busA.reqByteSelect = bsel[0]; assign busB.reqByteSelect = bsel[1];
    assign busA.reqDataWrite = wdat[0]; assign busB.reqDataWrite = wdat[1];
    assign busA.memDataRead = rdat[0]; assign busB.memDataRead = rdat[1];
    assign busA.memBusy = busy[0]; assign busB.memBusy = busy[1];

    assign oDone[0] = busA.reqDone;        assign oDone[1] = busB.reqDone;
    assign oErr[0]  = busA.reqError;       assign oErr[1]  = busB.reqError;
    assign oRead[0] = busA.reqDataRead;    assign oRead[1] = busB.reqDataRead;
    assign oEn[0]   = busA.memEnable;      assign oEn[1]   = busB.memEnable;
    assign oWe[0]   = busA.memWriteEnable; assign oWe[1]   = busB.memWriteEnable;
    assign oAddr[0] = busA.memAddress;     assign oAddr[1] = busB.memAddress;
    assign oBs[0]   = busA.memByteSelect;  assign oBs[1]   = busB.memByteSelect;
    assign oWd[0]   = busA.memDataWrite;   assign oWd[1]   = busB.memDataWrite;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port, whether the one-cycle bubble is pending,
    // how many busy cycles the owner has already waited, and who was served last.
    int         owner   [2] = '{-1, -1};
    bit         bubble  [2] = '{1'b0, 1'b0};
    int         busyRun [2] = '{0, 0};
    int         last    [2] = '{N - 1, N - 1};
    logic [N-1:0] lastDone [2];
    logic [N-1:0] lastErr  [2];

    always @(negedge clk) begin : compare
        logic [N-1:0]  eDone, eErr;
        logic          eEn, eWe;
        logic [AW-1:0] eAddr;
        logic [3:0]    eBs;
        logic [31:0]   eWd;
        int            g, c, limit;
        bit            found;
        for (int k = 0; k < 2; k++) begin
            eDone = '0; eErr = '0; eEn = 1'b0; eWe = 1'b0;
            eAddr = '0; eBs = '0; eWd = '0; g = 0;
            limit = (k == 0) ? TO_A : TO_B;
            if (rst) begin
                owner[k] = -1; bubble[k] = 1'b0; busyRun[k] = 0; last[k] = N - 1;
                check("reqDataRead", k, oRead[k], 0);
            end else if (owner[k] >= 0) begin
                g     = owner[k];
                eEn   = en[k][g];
                eWe   = we[k][g];
                eAddr = addr[k][g*AW +: AW];
                eBs   = bsel[k][g*4 +: 4];
                eWd   = wdat[k][g*32 +: 32];
                if (!en[k][g])                     eErr[g]  = 1'b1;
                else if (!busy[k])                 eDone[g] = 1'b1;
                else if (busyRun[k] + 1 >= limit)  eErr[g]  = 1'b1;
            end
            check("memEnable", k, oEn[k], eEn);
            check("memWriteEnable", k, oWe[k], eWe);
            check("memAddress", k, oAddr[k], eAddr);
            check("memByteSelect", k, oBs[k], eBs);
            check("memDataWrite", k, oWd[k], eWd);
            check("reqDone", k, oDone[k], eDone);
            check("reqError", k, oErr[k], eErr);
            if (eDone != '0 && !eWe) check("reqDataRead", k, oRead[k], rdat[k]);
            lastDone[k] = eDone;
            lastErr[k]  = eErr;
            if (!rst) begin
                if (owner[k] >= 0) begin
                    if ((eDone | eErr) != '0) begin
                        owner[k] = -1; bubble[k] = 1'b1;
                    end else begin
                        busyRun[k]++;
                    end
                end else if (bubble[k]) begin
                    bubble[k] = 1'b0;
                end else begin
                    found = 1'b0;
                    for (int s = 1; s <= N; s++) begin
                        c = (last[k] + s) % N;
                        if (!found && en[k][c]) begin
                            found = 1'b1; owner[k] = c; last[k] = c; busyRun[k] = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clearAll();
        for (int k = 0; k < 2; k++) begin
            en[k] = '0; we[k] = '0; addr[k] = '0; bsel[k] = '0;
            wdat[k] = '0; rdat[k] = '0; busy[k] = 1'b0;
        end
    endtask

    task automatic doReset();
        tick();
        rst = 1'b1;
        clearAll();
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic int bitIndex(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin : stimulus
        int           order [$];
        int           when  [$];
        logic [N-1:0] seen, dropped;
        int           enCycles;

        clearAll();
        sample();
        check("resetMemEnable", 0, oEn[0], 0);
        check("resetDone", 1, oDone[1], 0);
        check("resetError", 0, oErr[0], 0);
        check("resetRead", 0, oRead[0], 0);
        doReset();

        // Single read from requester 1 with no wait states.
        addr[0][1*AW +: AW] = 24'h000010;
        rdat[0] = 32'hDEADBEEF;
        en[0] = 3'b010;
        sample();
        check("t1IdleEnable", 0, oEn[0], 0);
        tick();
        sample();
        check("t1Enable", 0, oEn[0], 1);
        check("t1Done", 0, oDone[0], 3'b010);
        check("t1Read", 0, oRead[0], 32'hDEADBEEF);
        check("t1Address", 0, oAddr[0], 24'h000010);
        tick();
        en[0] = '0;
        sample();
        check("t1RecoverEnable", 0, oEn[0], 0);

        // Three persistent requesters rotate 0,1,2,0,1,2 with a three-cycle period.
        doReset();
        en[0] = 3'b111;
        dropped = '0;
        for (int cyc = 0; cyc < 40 && order.size() < 6; cyc++) begin
            sample();
            seen = oDone[0];
            if (seen != '0) begin
                order.push_back(bitIndex(seen));
                when.push_back(cyc);
            end
            tick();
            en[0] = en[0] | dropped;
            dropped = seen;
            en[0] = en[0] & ~seen;
        end
        check("t2GrantCount", 0, order.size(), 6);
        for (int i = 0; i < order.size(); i++) begin
            check("t2Order", 0, order[i], i % 3);
            if (i > 0) check("t2Period", 0, when[i] - when[i-1], 3);
        end

        // Write from requester 2 held off by four busy cycles.
        doReset();
        we[0] = 3'b100;
        bsel[0][2*4 +: 4] = 4'b0011;
        wdat[0][2*32 +: 32] = 32'h12345678;
        addr[0][2*AW +: AW] = 24'hABCDE0;
        busy[0] = 1'b1;
        en[0] = 3'b100;
        enCycles = 0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 5) busy[0] = 1'b0;
            sample();
            if (oEn[0]) enCycles++;
            check("t3WriteEnable", 0, oWe[0], 1);
            check("t3ByteSelect", 0, oBs[0], 4'b0011);
            check("t3DataWrite", 0, oWd[0], 32'h12345678);
            check("t3Done", 0, oDone[0], (c == 5) ? 3'b100 : 3'b000);
        end
        tick();
        en[0] = '0;
        sample();
        if (oEn[0]) enCycles++;
        check("t3EnableCycles", 0, enCycles, 5);

        // Timeout of four busy cycles, then a pending requester 0 is served.
        doReset();
        addr[1][0*AW +: AW] = 24'h000040;
        addr[1][1*AW +: AW] = 24'h000080;
        busy[1] = 1'b1;
        en[1] = 3'b010;
        tick();
        en[1] = 3'b011;
        sample();
        check("t4Enable", 1, oEn[1], 1);
        check("t4Address", 1, oAddr[1], 24'h000080);
        for (int c = 2; c <= 4; c++) begin
            tick();
            sample();
            check("t4Error", 1, oErr[1], (c == 4) ? 3'b010 : 3'b000);
            check("t4NoDone", 1, oDone[1], 0);
        end
        tick();
        en[1] = 3'b001;
        sample();
        check("t4RecoverEnable", 1, oEn[1], 0);
        check("t4RecoverError", 1, oErr[1], 0);
        tick();
        busy[1] = 1'b0;
        sample();
        check("t4IdleEnable", 1, oEn[1], 0);
        tick();
        sample();
        check("t4NextDone", 1, oDone[1], 3'b001);
        check("t4NextAddress", 1, oAddr[1], 24'h000040);
        tick();
        en[1] = '0;

        // Withdrawal in the second grant cycle, then reset during a later grant.
        doReset();
        busy[0] = 1'b1;
        en[0] = 3'b001;
        tick();
        sample();
        check("t5Enable", 0, oEn[0], 1);
        tick();
        en[0] = '0;
        sample();
        check("t5WithdrawEnable", 0, oEn[0], 0);
        check("t5WithdrawError", 0, oErr[0], 3'b001);
        check("t5WithdrawDone", 0, oDone[0], 0);
        tick();
        tick();
        en[0] = 3'b010;
        tick();
        sample();
        check("t5SecondGrant", 0, oEn[0], 1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("t5ResetEnable", 0, oEn[0], 0);
        check("t5ResetAddress", 0, oAddr[0], 0);
        check("t5ResetDone", 0, oDone[0], 0);
        check("t5ResetError", 0, oErr[0], 0);
        en[0] = 3'b011;
        busy[0] = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        sample();
        check("t5AfterResetDone", 0, oDone[0], 3'b001);
        tick();
        en[0] = '0;

        // Random traffic on both instances; the compare process checks every cycle.
        doReset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < N; i++) begin
                    if (en[k][i] && (lastDone[k][i] || lastErr[k][i])) begin
                        en[k][i] = 1'b0;
                    end else if (en[k][i] && $urandom_range(0, 63) == 0) begin
                        en[k][i] = 1'b0;
                    end else if (!en[k][i] && $urandom_range(0, 2) == 0) begin
                        en[k][i] = 1'b1;
                        we[k][i] = 1'($urandom_range(0, 1));
                        addr[k][i*AW +: AW] = AW'($urandom);
                        bsel[k][i*4 +: 4] = 4'($urandom);
                        wdat[k][i*32 +: 32] = $urandom;
                    end
                end
                busy[k] = (k == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
                rdat[k] = $urandom;
            end
        end
        tick();
        clearAll();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
